// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment/extension, x0 write suppression,
// registered write-back mux inputs and a retired-instruction counter.
module mem_wb_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [1:0]        LoadSizeM,
    input  logic              LoadUnsignedM,
    input  logic [DATA_W-1:0] MemOut,
    input  logic [DATA_W-1:0] AluOutM,
    input  logic [REG_AW-1:0] WriteRegM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] AluOutW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic [DATA_W-1:0] ResultW,
    output logic [CNT_W-1:0]  RetireCount
);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [REG_AW-1:0] writereg_q, writereg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       field;
    int                field_w;
    logic              sign_bit;
    logic [DATA_W-1:0] ext_data;
    logic              rw_cap;

    // Select the addressed lane, then fill every bit above it with the sign (or 0).
    always_comb begin
        field   = '0;
        field_w = 32;
        case (LoadSizeM)
            2'b00: begin
                field[7:0] = MemOut[{AluOutM[1:0], 3'b000} +: 8];
                field_w    = 8;
            end
            2'b01: begin
                field[15:0] = AluOutM[1] ? MemOut[31:16] : MemOut[15:0];
                field_w     = 16;
            end
            default: field = MemOut[31:0];
        endcase
        case (LoadSizeM)
            2'b00:   sign_bit = ~LoadUnsignedM & field[7];
            2'b01:   sign_bit = ~LoadUnsignedM & field[15];
            default: sign_bit = ~LoadUnsignedM & field[31];
        endcase
        ext_data       = '0;
        ext_data[31:0] = field;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= field_w) ext_data[i] = sign_bit;
        end
    end

    assign rw_cap = RegWriteM & ValidM & ~((ZERO_SUPPRESS != 0) & (WriteRegM == '0));

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        readdata_d = readdata_q;
        aluout_d   = aluout_q;
        writereg_d = writereg_q;
        cnt_d      = cnt_q;
        if (FlushW) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            readdata_d = '0;
            aluout_d   = '0;
            writereg_d = '0;
        end else if (!StallW) begin
            valid_d    = ValidM;
            regwrite_d = rw_cap;
            memtoreg_d = MemtoRegM & ValidM;
            readdata_d = ext_data;
            aluout_d   = AluOutM;
            writereg_d = WriteRegM;
            cnt_d      = cnt_q + CNT_W'(ValidM);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            readdata_q <= '0;
            aluout_q   <= '0;
            writereg_q <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            readdata_q <= readdata_d;
            aluout_q   <= aluout_d;
            writereg_q <= writereg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ValidW      = valid_q;
    assign RegWriteW   = regwrite_q;
    assign MemtoRegW   = memtoreg_q;
    assign ReadDataW   = readdata_q;
    assign AluOutW     = aluout_q;
    assign WriteRegW   = writereg_q;
    assign ResultW     = memtoreg_q ? readdata_q : aluout_q;
    assign RetireCount = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected W-stage state per cycle,
// a negedge monitor pops and compares. A second instance runs with a 4-bit counter.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, StallW, FlushW, ValidM, RegWriteM, MemtoRegM, LoadUnsignedM;
    logic [1:0]  LoadSizeM;
    logic [31:0] MemOut, AluOutM;
    logic [4:0]  WriteRegM;

    logic        ValidW, RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, AluOutW, ResultW, RetireCount;
    logic [4:0]  WriteRegW;

    logic        v4, rw4, m2r4;
    logic [31:0] rd4, alu4, res4;
    logic [4:0]  wr4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LoadSizeM(LoadSizeM),
        .LoadUnsignedM(LoadUnsignedM), .MemOut(MemOut), .AluOutM(AluOutM),
        .WriteRegM(WriteRegM), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW), .AluOutW(AluOutW),
        .WriteRegW(WriteRegW), .ResultW(ResultW), .RetireCount(RetireCount)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LoadSizeM(LoadSizeM),
        .LoadUnsignedM(LoadUnsignedM), .MemOut(MemOut), .AluOutM(AluOutM),
        .WriteRegM(WriteRegM), .ValidW(v4), .RegWriteW(rw4),
        .MemtoRegW(m2r4), .ReadDataW(rd4), .AluOutW(alu4),
        .WriteRegW(wr4), .ResultW(res4), .RetireCount(cnt4)
    );

    typedef struct packed {
        logic        v, rw, m2r;
        logic [31:0] rd, alu, res;
        logic [4:0]  wr;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    // expected W-stage state
    logic        e_v, e_rw, e_m2r;
    logic [31:0] e_rd, e_alu, e_cnt;
    logic [4:0]  e_wr;
    logic [3:0]  e_cnt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ValidW",      32'(ValidW),    32'(e.v));
            chk("RegWriteW",   32'(RegWriteW), 32'(e.rw));
            chk("MemtoRegW",   32'(MemtoRegW), 32'(e.m2r));
            chk("ReadDataW",   ReadDataW,      e.rd);
            chk("AluOutW",     AluOutW,        e.alu);
            chk("WriteRegW",   32'(WriteRegW), 32'(e.wr));
            chk("ResultW",     ResultW,        e.res);
            chk("RetireCount", RetireCount,    e.cnt);
            chk("RetireCount4", 32'(cnt4),     32'(e.cnt4));
            chk("ReadDataW4",  rd4,            e.rd);
        end
    end

    task automatic set_in(input logic vm, input logic rw, input logic m2r, input logic [1:0] sz,
                          input logic uns, input logic [31:0] mem, input logic [31:0] alu,
                          input logic [4:0] wr);
        ValidM = vm; RegWriteM = rw; MemtoRegM = m2r; LoadSizeM = sz;
        LoadUnsignedM = uns; MemOut = mem; AluOutM = alu; WriteRegM = wr;
    endtask

    // exp_rd: hand-computed aligned load value for the current inputs
    task automatic tick(input logic [31:0] exp_rd);
        exp_t e;
        if (!rst_n) begin
            e_v = 0; e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wr = 0; e_cnt = 0; e_cnt4 = 0;
        end else if (FlushW) begin
            e_v = 0; e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_wr = 0;
        end else if (!StallW) begin
            e_v   = ValidM;
            e_rw  = RegWriteM & ValidM & (WriteRegM != 5'd0);
            e_m2r = MemtoRegM & ValidM;
            e_rd  = exp_rd;
            e_alu = AluOutM;
            e_wr  = WriteRegM;
            if (ValidM) begin
                e_cnt  = e_cnt + 1;
                e_cnt4 = e_cnt4 + 4'd1;
            end
        end
        e.v = e_v; e.rw = e_rw; e.m2r = e_m2r; e.rd = e_rd; e.alu = e_alu;
        e.res = e_m2r ? e_rd : e_alu; e.wr = e_wr; e.cnt = e_cnt; e.cnt4 = e_cnt4;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] MW = 32'h80FF_7F01;

    initial begin
        rst_n = 0; StallW = 0; FlushW = 0;
        set_in(0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            StallW = 1'($urandom); FlushW = 1'($urandom);
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom));
            tick(32'h0);
        end
        rst_n = 1; StallW = 0; FlushW = 0;

        // byte / half / word alignment
        set_in(1, 1, 1, 2'b00, 0, MW, 32'h1000_0000, 5'd1); tick(32'h0000_0001);
        set_in(1, 1, 1, 2'b00, 0, MW, 32'h1000_0001, 5'd2); tick(32'h0000_007F);
        set_in(1, 1, 1, 2'b00, 0, MW, 32'h1000_0002, 5'd3); tick(32'hFFFF_FFFF);
        set_in(1, 1, 1, 2'b00, 0, MW, 32'h1000_0003, 5'd4); tick(32'hFFFF_FF80);
        set_in(1, 1, 1, 2'b00, 1, MW, 32'h1000_0003, 5'd5); tick(32'h0000_0080);
        set_in(1, 1, 1, 2'b01, 0, MW, 32'h1000_0002, 5'd6); tick(32'hFFFF_80FF);
        set_in(1, 1, 1, 2'b01, 1, MW, 32'h1000_0003, 5'd7); tick(32'h0000_80FF);
        set_in(1, 1, 1, 2'b01, 0, MW, 32'h1000_0001, 5'd8); tick(32'h0000_7F01);
        set_in(1, 1, 1, 2'b10, 0, MW, 32'h1000_0000, 5'd9); tick(32'h80FF_7F01);
        set_in(1, 1, 1, 2'b11, 1, MW, 32'h1000_0000, 5'd9); tick(32'h80FF_7F01);
        // ALU result path, alignment still computed
        set_in(1, 1, 0, 2'b00, 0, MW, 32'h1234_5678, 5'd10); tick(32'h0000_0001);

        // x0 suppression
        set_in(1, 1, 0, 2'b10, 0, MW, 32'hAAAA_0000, 5'd0); tick(32'h80FF_7F01);
        set_in(1, 1, 0, 2'b10, 0, MW, 32'hAAAA_0004, 5'd5); tick(32'h80FF_7F01);
        // ValidM=0 qualifies write/memtoreg, data still captured
        set_in(0, 1, 1, 2'b00, 1, MW, 32'h0000_0002, 5'd6); tick(32'h0000_00FF);

        // stall 3 cycles with changing inputs, then release
        set_in(1, 1, 1, 2'b10, 0, 32'h0000_1111, 32'h0000_0040, 5'd11); tick(32'h0000_1111);
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 2'b10, 0, 32'h2222_0000 + 32'(i), 32'h3300_0000 + 32'(i), 5'(12 + i));
            tick(32'h0);
        end
        StallW = 0;
        set_in(1, 1, 0, 2'b00, 1, 32'h0000_00C3, 32'h0000_0050, 5'd15); tick(32'h0000_00C3);

        // flush + stall: flush wins
        FlushW = 1; StallW = 1;
        set_in(1, 1, 1, 2'b10, 0, 32'h5555_5555, 32'h6666_6666, 5'd20); tick(32'h5555_5555);
        FlushW = 1; StallW = 0;
        set_in(1, 1, 0, 2'b10, 0, 32'h5555_5555, 32'h7777_7777, 5'd21); tick(32'h5555_5555);
        FlushW = 0;

        // counter wrap on the 4-bit instance: 17 valid captures from reset, invalids interleaved
        rst_n = 0; tick(32'h0);
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4 || i == 9 || i == 15)
                set_in(0, 1, 0, 2'b10, 0, 32'(i), 32'(i), 5'd1);
            else
                set_in(1, 1, 0, 2'b10, 0, 32'(i), 32'(i), 5'd1);
            tick(32'(i));
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
